// File: rtl/instr_fetch_stage.sv
// IF stage: program counter, synchronous-read instruction memory and the next_pc/instr pair for IF/ID.
// Define IF_HALT_DETECT_EN to enable the RUN/HALTED state machine and the halted output.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   next_pc_out,
  output logic [31:0]   instr_out,
  output logic [31:0]   pc_out,
  output logic          valid_out,
  output logic          halted
);

  logic [31:0]   mem [IMEM_DEPTH];
  logic [31:0]   mem_q;
  logic [31:0]   pc_reg;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;
  logic [AW-1:0] rd_addr;
  logic          run;
  logic          halt_hit;
  logic          unused_bits;

  assign pc_plus4 = pc_reg + 32'd4;

  // Addressing the RAM with pc_next keeps mem_q aligned with pc_reg one cycle later.
  assign rd_addr = pc_next[AW+1:2];

  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
    mem_q <= mem[rd_addr];
  end

`ifdef IF_HALT_DETECT_EN
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // A redirect or stall in the same cycle suppresses the halt word.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:    if (mem_q == HALT_WORD && !stall && !branch_taken) state_next = HALTED;
      HALTED: state_next = HALTED;
    endcase
  end

  assign run         = (state_reg == RUN);
  assign halt_hit    = run && (state_next == HALTED);
  assign unused_bits = ^branch_target[1:0];
`else
  assign run         = 1'b1;
  assign halt_hit    = 1'b0;
  assign unused_bits = ^{branch_target[1:0], HALT_WORD};
`endif

  always_comb begin
    pc_next = pc_plus4;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (run && branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (!run || stall || halt_hit) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_comb begin
    pc_out      = pc_reg;
    next_pc_out = pc_plus4;
    instr_out   = mem_q;
    valid_out   = 1'b1;
    halted      = 1'b0;
    if (reset) begin
      pc_out      = 32'h0;
      next_pc_out = 32'h0;
      instr_out   = NOP_WORD;
      valid_out   = 1'b0;
    end else if (!run) begin
      instr_out   = NOP_WORD;
      valid_out   = 1'b0;
      halted      = 1'b1;
    end else if (branch_taken) begin
      instr_out   = NOP_WORD;
      valid_out   = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: each row drives one cycle and queues the outputs expected in it.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] next_pc_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic r, s, b, we;
    logic [7:0]  wa;
    logic [31:0] wd, tgt, pc, npc, instr;
    logic v, h;
  } row_t;

  typedef struct {
    logic [31:0] pc, npc, instr;
    logic v, h;
  } exp_t;

  exp_t sb[$];

  instr_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .next_pc_out  (next_pc_out),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic r, input logic s, input logic b, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] instr,
                              input logic v, input logic h);
    row_t x;
    x.r = r; x.s = s; x.b = b; x.we = 1'b0; x.wa = 8'h0; x.wd = 32'h0;
    x.tgt = tgt; x.pc = pc; x.npc = npc; x.instr = instr; x.v = v; x.h = h;
    return x;
  endfunction

  function automatic row_t rs();
    return mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic row_t rn(input logic [31:0] pc, input logic [31:0] instr);
    return mk(1'b0, 1'b0, 1'b0, 32'h0, pc, pc + 32'd4, instr, 1'b1, 1'b0);
  endfunction

  function automatic row_t st(input logic [31:0] pc, input logic [31:0] instr);
    return mk(1'b0, 1'b1, 1'b0, 32'h0, pc, pc + 32'd4, instr, 1'b1, 1'b0);
  endfunction

  function automatic row_t br(input logic [31:0] pc, input logic [31:0] tgt, input logic s);
    return mk(1'b0, s, 1'b1, tgt, pc, pc + 32'd4, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic row_t hl(input logic [31:0] pc, input logic s, input logic b, input logic [31:0] tgt);
    return mk(1'b0, s, b, tgt, pc, pc + 32'd4, 32'h0, 1'b0, 1'b1);
  endfunction

  function automatic row_t wr(input row_t x, input logic [7:0] a, input logic [31:0] d);
    row_t y;
    y = x; y.we = 1'b1; y.wa = a; y.wd = d;
    return y;
  endfunction

  task automatic apply(input row_t x);
    exp_t e;
    @(posedge clk);
    #1;
    reset = x.r; stall = x.s; branch_taken = x.b; branch_target = x.tgt;
    imem_we = x.we; imem_waddr = x.wa; imem_wdata = x.wd;
    e.pc = x.pc; e.npc = x.npc; e.instr = x.instr; e.v = x.v; e.h = x.h;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t q[$];
    exp_t e;
    q.push_back(wr(rs(), 8'd0,   32'h2001_0005));
    q.push_back(wr(rs(), 8'd1,   32'h2002_0007));
    q.push_back(wr(rs(), 8'd2,   32'h0022_1820));
    q.push_back(wr(rs(), 8'd3,   32'h0000_0000));
    q.push_back(wr(rs(), 8'd4,   32'h4444_4444));
    q.push_back(wr(rs(), 8'd5,   32'h5555_5555));
    q.push_back(wr(rs(), 8'd6,   32'h6666_6666));
    q.push_back(wr(rs(), 8'd7,   32'h7777_7777));
    q.push_back(wr(rs(), 8'd8,   32'hBBBB_0020));
    q.push_back(wr(rs(), 8'd9,   32'h9999_9999));
    q.push_back(wr(rs(), 8'd16,  32'hAAAA_0010));
    q.push_back(wr(rs(), 8'd17,  32'hAAAA_0011));
    q.push_back(wr(rs(), 8'd255, 32'hCCCC_03FC));
    q.push_back(rs());
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL reset[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   reset[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  task automatic test_sequential();
    row_t q[$];
    exp_t e;
    q.push_back(rn(32'h00, 32'h2001_0005));
    q.push_back(rn(32'h04, 32'h2002_0007));
    q.push_back(rn(32'h08, 32'h0022_1820));
    q.push_back(rn(32'h0C, 32'h0000_0000));
    q.push_back(rn(32'h10, 32'h4444_4444));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL sequential[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   sequential[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  task automatic test_stall();
    row_t q[$];
    exp_t e;
    q.push_back(rs());
    q.push_back(rn(32'h00, 32'h2001_0005));
    q.push_back(rn(32'h04, 32'h2002_0007));
    q.push_back(st(32'h08, 32'h0022_1820));
    q.push_back(st(32'h08, 32'h0022_1820));
    q.push_back(st(32'h08, 32'h0022_1820));
    q.push_back(rn(32'h08, 32'h0022_1820));
    q.push_back(rn(32'h0C, 32'h0000_0000));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL stall[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   stall[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  task automatic test_branch();
    row_t q[$];
    exp_t e;
    q.push_back(rs());
    q.push_back(rn(32'h00, 32'h2001_0005));
    q.push_back(br(32'h04, 32'h0000_0043, 1'b0));
    q.push_back(rn(32'h40, 32'hAAAA_0010));
    q.push_back(br(32'h44, 32'h0000_0020, 1'b1));
    q.push_back(st(32'h20, 32'hBBBB_0020));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL branch[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   branch[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  task automatic test_collision();
    row_t q[$];
    exp_t e;
    q.push_back(wr(st(32'h20, 32'hBBBB_0020), 8'd8, 32'hDDDD_0020));
    q.push_back(st(32'h20, 32'hBBBB_0020));
    q.push_back(rn(32'h20, 32'hDDDD_0020));
    q.push_back(rn(32'h24, 32'h9999_9999));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL collision[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   collision[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  task automatic test_wrap();
    row_t q[$];
    exp_t e;
    q.push_back(br(32'h28, 32'h0000_03FE, 1'b0));
    q.push_back(rn(32'h3FC, 32'hCCCC_03FC));
    q.push_back(rn(32'h400, 32'h2001_0005));
    q.push_back(br(32'h404, 32'hFFFF_FFFF, 1'b0));
    q.push_back(rn(32'hFFFF_FFFC, 32'hCCCC_03FC));
    q.push_back(rn(32'h00, 32'h2001_0005));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   wrap[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  task automatic test_halt();
    row_t q[$];
    exp_t e;
    q.push_back(wr(rs(), 8'd5, 32'hFFFF_FFFF));
    q.push_back(rn(32'h00, 32'h2001_0005));
    q.push_back(rn(32'h04, 32'h2002_0007));
    q.push_back(rn(32'h08, 32'h0022_1820));
    q.push_back(rn(32'h0C, 32'h0000_0000));
    q.push_back(rn(32'h10, 32'h4444_4444));
    q.push_back(rn(32'h14, 32'hFFFF_FFFF));
`ifdef IF_HALT_DETECT_EN
    for (int k = 0; k < 10; k++) begin
      q.push_back(hl(32'h14, (k == 4), (k == 6), 32'h0000_0040));
    end
`else
    q.push_back(rn(32'h18, 32'h6666_6666));
    q.push_back(br(32'h1C, 32'h0000_0040, 1'b0));
    q.push_back(rn(32'h40, 32'hAAAA_0010));
    q.push_back(rn(32'h44, 32'hAAAA_0011));
`endif
    q.push_back(rs());
    q.push_back(rn(32'h00, 32'h2001_0005));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({pc_out, next_pc_out, instr_out, valid_out, halted} !== {e.pc, e.npc, e.instr, e.v, e.h}) begin
        n_bad++;
        $display("FAIL halt[%0d]: got pc=%h npc=%h instr=%h valid=%b halted=%b, want pc=%h npc=%h instr=%h valid=%b halted=%b",
                 i, pc_out, next_pc_out, instr_out, valid_out, halted, e.pc, e.npc, e.instr, e.v, e.h);
      end else
        $display("ok   halt[%0d] pc=%h instr=%h valid=%b halted=%b", i, pc_out, instr_out, valid_out, halted);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_collision();
    test_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
